// File: rtl/fp_div_pkg.sv
// Shared definitions for the pipelined IEEE-754 divider:
// flag bit positions, operand classes and width helper functions.
package fp_div_pkg;

  // Bit positions inside the 5-bit flags word {invalid, div_by_zero, overflow, underflow, inexact}
  localparam int FLG_INVALID   = 4;
  localparam int FLG_DIV_ZERO  = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;
  localparam int FLG_W         = 5;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_QNAN = 3'd4,
    CLS_SNAN = 3'd5
  } op_cls_e;

  // Number of restoring steps: hidden bit + fraction + guard + one spare
  // so that both normalisation cases still have a guard bit.
  function automatic int q_steps(input int man_w);
    return man_w + 3;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  // Returned wide; callers truncate to their word width.
  function automatic logic [127:0] canon_qnan(input int exp_w, input int man_w);
    logic [127:0] v;
    v = ((128'd1 << exp_w) - 128'd1) << man_w;
    v = v | (128'd1 << (man_w - 1));
    return v;
  endfunction

  // Classify an operand from its exponent/fraction summary bits.
  function automatic op_cls_e classify(input logic exp_ones, input logic exp_zero,
                                       input logic frac_zero, input logic frac_msb);
    op_cls_e c;
    if (exp_zero) begin
      c = frac_zero ? CLS_ZERO : CLS_SUB;
    end else if (exp_ones) begin
      if (frac_zero) begin
        c = CLS_INF;
      end else begin
        c = frac_msb ? CLS_QNAN : CLS_SNAN;
      end
    end else begin
      c = CLS_NORM;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp_div_pipe_param_step.sv
// One registered restoring-division step. Carries remainder, partial
// quotient, divisor, enable and an opaque metadata word; everything
// holds when adv is low (global stall).
module fp_div_step
  import fp_div_pkg::*;
#(
  parameter int MAN_W  = 23,
  parameter int Q      = 26,
  parameter int META_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic              vld,
  input  logic              en,
  input  logic [MAN_W+1:0]  rem,
  input  logic [Q-1:0]      quo,
  input  logic [MAN_W:0]    dvs,
  input  logic [META_W-1:0] meta,
  output logic              vld_r,
  output logic              en_r,
  output logic [MAN_W+1:0]  rem_r,
  output logic [Q-1:0]      quo_r,
  output logic [MAN_W:0]    dvs_r,
  output logic [META_W-1:0] meta_r
);

  logic             ge_s;
  logic [MAN_W+1:0] diff_s;
  logic [MAN_W+1:0] rem_nx_s;
  logic [Q-1:0]     quo_nx_s;

  assign ge_s   = (rem >= {1'b0, dvs});
  assign diff_s = rem - {1'b0, dvs};

  // Next remainder / quotient; disabled (special or bubble) entries stay zero
  always_comb begin
    rem_nx_s = '0;
    quo_nx_s = '0;
    if (!en) begin
      rem_nx_s = '0;
      quo_nx_s = '0;
    end else if (ge_s) begin
      rem_nx_s = diff_s << 1'b1;
      quo_nx_s = (quo << 1'b1) | {{(Q-1){1'b0}}, 1'b1};
    end else begin
      rem_nx_s = rem << 1'b1;
      quo_nx_s = quo << 1'b1;
    end
  end

  // Stage register, advancing only when the pipe is not stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r  <= 1'b0;
      en_r   <= 1'b0;
      rem_r  <= '0;
      quo_r  <= '0;
      dvs_r  <= '0;
      meta_r <= '0;
    end else if (adv) begin
      vld_r  <= vld;
      en_r   <= en;
      rem_r  <= rem_nx_s;
      quo_r  <= quo_nx_s;
      dvs_r  <= dvs;
      meta_r <= meta;
    end
  end

endmodule

// File: rtl/fp_div_pipe_param.sv
// Fully pipelined parametrised IEEE-754 divider (DAZ inputs, FTZ outputs).
// Decode stage, Q restoring steps, then normalise/round/pack into the
// output register. A single global stall holds every stage while the
// output is occupied and not taken.
// Build option: define FP_DIV_RNE_EN for round-to-nearest-even; otherwise
// the quotient is truncated (inexact is still reported).
module fp_div_pipe_param
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  output logic               ready_in,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic               valid_out,
  input  logic               ready_out,
  output logic [EXP_W+MAN_W:0] result,
  output logic [4:0]         flags
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int Q      = q_steps(MAN_W);
  localparam int EW     = EXP_W + 2;
  localparam int META_W = 1 + EW + W + FLG_W;

  localparam logic [W-1:0]         QNAN_C     = W'(canon_qnan(EXP_W, MAN_W));
  localparam logic [EW-1:0]        BIAS_C     = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX_C  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ONE_C  = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO_C = '0;

  // ---------------- decode ----------------
  op_cls_e          cls_a_s, cls_b_s;
  logic             zero_a_s, zero_b_s, inf_a_s, inf_b_s;
  logic             nan_a_s, nan_b_s, snan_a_s, snan_b_s;
  logic             sign_s;
  logic [EW-1:0]    e_s;
  logic             spec_s;
  logic [W-1:0]     spec_res_s;
  logic [FLG_W-1:0] spec_flg_s;

  assign ready_in = !valid_out || ready_out;

  assign cls_a_s = classify(&a[W-2:MAN_W], ~|a[W-2:MAN_W], ~|a[MAN_W-1:0], a[MAN_W-1]);
  assign cls_b_s = classify(&b[W-2:MAN_W], ~|b[W-2:MAN_W], ~|b[MAN_W-1:0], b[MAN_W-1]);

  // Subnormals are read as zero
  assign zero_a_s = (cls_a_s == CLS_ZERO) || (cls_a_s == CLS_SUB);
  assign zero_b_s = (cls_b_s == CLS_ZERO) || (cls_b_s == CLS_SUB);
  assign inf_a_s  = (cls_a_s == CLS_INF);
  assign inf_b_s  = (cls_b_s == CLS_INF);
  assign snan_a_s = (cls_a_s == CLS_SNAN);
  assign snan_b_s = (cls_b_s == CLS_SNAN);
  assign nan_a_s  = (cls_a_s == CLS_QNAN) || snan_a_s;
  assign nan_b_s  = (cls_b_s == CLS_QNAN) || snan_b_s;

  assign sign_s = a[W-1] ^ b[W-1];
  assign e_s    = {2'b00, a[W-2:MAN_W]} - {2'b00, b[W-2:MAN_W]} + BIAS_C;

  // Special-case bypass word, highest priority first
  always_comb begin
    spec_s     = 1'b0;
    spec_res_s = '0;
    spec_flg_s = '0;
    if (nan_a_s || nan_b_s) begin
      spec_s                  = 1'b1;
      spec_res_s              = QNAN_C;
      spec_flg_s[FLG_INVALID] = snan_a_s || snan_b_s;
    end else if ((zero_a_s && zero_b_s) || (inf_a_s && inf_b_s)) begin
      spec_s                  = 1'b1;
      spec_res_s              = QNAN_C;
      spec_flg_s[FLG_INVALID] = 1'b1;
    end else if (inf_a_s) begin
      spec_s     = 1'b1;
      spec_res_s = {sign_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (inf_b_s) begin
      spec_s     = 1'b1;
      spec_res_s = {sign_s, {(W-1){1'b0}}};
    end else if (zero_b_s) begin
      spec_s                   = 1'b1;
      spec_res_s               = {sign_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_flg_s[FLG_DIV_ZERO] = 1'b1;
    end else if (zero_a_s) begin
      spec_s     = 1'b1;
      spec_res_s = {sign_s, {(W-1){1'b0}}};
    end else begin
      spec_s = 1'b0;
    end
  end

  logic              d_vld_r, d_en_r;
  logic [MAN_W+1:0]  d_rem_r;
  logic [MAN_W:0]    d_dvs_r;
  logic [META_W-1:0] d_meta_r;

  // Decode register: operands enter only on a transfer (ready_in is the advance)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_vld_r  <= 1'b0;
      d_en_r   <= 1'b0;
      d_rem_r  <= '0;
      d_dvs_r  <= '0;
      d_meta_r <= '0;
    end else if (ready_in) begin
      d_vld_r  <= valid_in;
      d_en_r   <= valid_in && !spec_s;
      d_rem_r  <= (valid_in && !spec_s) ? {2'b01, a[MAN_W-1:0]} : '0;
      d_dvs_r  <= {1'b1, b[MAN_W-1:0]};
      d_meta_r <= {sign_s, e_s, spec_res_s, spec_flg_s};
    end
  end

  // ---------------- divide chain ----------------
  logic              vld_c  [0:Q];
  logic              en_c   [0:Q];
  logic [MAN_W+1:0]  rem_c  [0:Q];
  logic [Q-1:0]      quo_c  [0:Q];
  logic [MAN_W:0]    dvs_c  [0:Q];
  logic [META_W-1:0] meta_c [0:Q];

  assign vld_c[0]  = d_vld_r;
  assign en_c[0]   = d_en_r;
  assign rem_c[0]  = d_rem_r;
  assign quo_c[0]  = '0;
  assign dvs_c[0]  = d_dvs_r;
  assign meta_c[0] = d_meta_r;

  for (genvar i = 0; i < Q; i++) begin : g_step
    fp_div_step #(
      .MAN_W (MAN_W),
      .Q     (Q),
      .META_W(META_W)
    ) u_step (
      .clk   (clk),
      .rst   (rst),
      .adv   (ready_in),
      .vld   (vld_c[i]),
      .en    (en_c[i]),
      .rem   (rem_c[i]),
      .quo   (quo_c[i]),
      .dvs   (dvs_c[i]),
      .meta  (meta_c[i]),
      .vld_r (vld_c[i+1]),
      .en_r  (en_c[i+1]),
      .rem_r (rem_c[i+1]),
      .quo_r (quo_c[i+1]),
      .dvs_r (dvs_c[i+1]),
      .meta_r(meta_c[i+1])
    );
  end

  // The divisor copy leaving the last step has no consumer
  logic unused_dvs_s;
  assign unused_dvs_s = ^dvs_c[Q];

  // ---------------- normalise / round / pack ----------------
  logic                   sign_f_s;
  logic signed [EW-1:0]   exp_f_s;
  logic [W-1:0]           spec_res_f_s;
  logic [FLG_W-1:0]       spec_flg_f_s;
  logic [Q-1:0]           q_s;
  logic [MAN_W+1:0]       rem_f_s;
  logic [MAN_W-1:0]       frac_s, frac_r_s;
  logic                   guard_s, sticky_s;
  logic signed [EW-1:0]   exp_n_s, exp_r_s;
  logic [W-1:0]           res_s;
  logic [FLG_W-1:0]       flg_s;

  assign {sign_f_s, exp_f_s, spec_res_f_s, spec_flg_f_s} = meta_c[Q];
  assign q_s     = quo_c[Q];
  assign rem_f_s = rem_c[Q];

  // Normalise: quotient in [1,2) keeps the exponent, in [0.5,1) shifts and decrements
  always_comb begin
    frac_s   = '0;
    guard_s  = 1'b0;
    sticky_s = 1'b0;
    exp_n_s  = exp_f_s;
    if (q_s[Q-1]) begin
      frac_s   = q_s[Q-2:2];
      guard_s  = q_s[1];
      sticky_s = (|rem_f_s) | q_s[0];
      exp_n_s  = exp_f_s;
    end else begin
      frac_s   = q_s[Q-3:1];
      guard_s  = q_s[0];
      sticky_s = |rem_f_s;
      exp_n_s  = exp_f_s - EXP_ONE_C;
    end
  end

`ifdef FP_DIV_RNE_EN
  logic inc_s;
  // Round to nearest even; an all-ones fraction wraps to zero and bumps the exponent
  always_comb begin
    inc_s    = guard_s & (sticky_s | frac_s[0]);
    frac_r_s = frac_s + {{(MAN_W-1){1'b0}}, inc_s};
    if (inc_s && (&frac_s)) begin
      exp_r_s = exp_n_s + EXP_ONE_C;
    end else begin
      exp_r_s = exp_n_s;
    end
  end
`else
  // Truncation: guard is dropped, nothing is incremented
  always_comb begin
    frac_r_s = frac_s;
    exp_r_s  = exp_n_s;
  end
`endif

  // Pack: bypass word for specials, otherwise range-check the rounded exponent
  always_comb begin
    res_s = '0;
    flg_s = '0;
    if (!en_c[Q]) begin
      res_s = spec_res_f_s;
      flg_s = spec_flg_f_s;
    end else if (exp_r_s >= EXP_MAX_C) begin
      res_s                = {sign_f_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_s[FLG_OVERFLOW]  = 1'b1;
      flg_s[FLG_INEXACT]   = 1'b1;
    end else if (exp_r_s <= EXP_ZERO_C) begin
      res_s                = {sign_f_s, {(W-1){1'b0}}};
      flg_s[FLG_UNDERFLOW] = 1'b1;
      flg_s[FLG_INEXACT]   = 1'b1;
    end else begin
      res_s              = {sign_f_s, exp_r_s[EXP_W-1:0], frac_r_s};
      flg_s[FLG_INEXACT] = guard_s | sticky_s;
    end
  end

  // Output register; holds result and flags stable while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (ready_in) begin
      valid_out <= vld_c[Q];
      result    <= res_s;
      flags     <= flg_s;
    end
  end

endmodule
